// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus a 2-entry {pc, instr} prefetch buffer with redirect/flush.
// Optional misaligned-redirect halt is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] h_pc_q, h_pc_d, h_in_q, h_in_d;
  logic [31:0] t_pc_q, t_pc_d, t_in_q, t_in_d;
  logic        pop, fetch, bad;
  assign imem_a      = pc_q;
  assign instr       = h_in_q;
  assign instr_pc    = h_pc_q;
  assign instr_valid = (state_q == ONE) || (state_q == FULL);
  assign pop         = instr_valid && instr_ready;
  assign fetch       = (state_q != HALT) && !redirect && ((state_q != FULL) || pop);
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad      = redirect_pc[1:0] != 2'b00;
  assign misalign = state_q == HALT;
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    h_pc_d  = h_pc_q;
    h_in_d  = h_in_q;
    t_pc_d  = t_pc_q;
    t_in_d  = t_in_q;
    if (state_q != HALT && redirect) begin
      // a misaligned target halts with the PC left where it was
      state_d = bad ? HALT : EMPTY;
      pc_d    = bad ? pc_q : (redirect_pc & 32'hFFFF_FFFC);
    end else if (fetch) begin
      pc_d = pc_q + 32'd4;
      case (state_q)
        EMPTY: begin
          state_d = ONE;
          h_pc_d  = pc_q;
          h_in_d  = imem_rd;
        end
        ONE: begin
          state_d = pop ? ONE : FULL;
          h_pc_d  = pop ? pc_q : h_pc_q;
          h_in_d  = pop ? imem_rd : h_in_q;
          t_pc_d  = pop ? t_pc_q : pc_q;
          t_in_d  = pop ? t_in_q : imem_rd;
        end
        FULL: begin
          h_pc_d = t_pc_q;
          h_in_d = t_in_q;
          t_pc_d = pc_q;
          t_in_d = imem_rd;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      pc_q    <= RESET_PC;
      h_pc_q  <= 32'h0;
      h_in_q  <= 32'h0;
      t_pc_q  <= 32'h0;
      t_in_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      h_pc_q  <= h_pc_d;
      h_in_q  <= h_in_d;
      t_pc_q  <= t_pc_d;
      t_in_q  <= t_in_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a queue-based fetch model.
module tb_fetch_unit;
  logic        clk, reset, redirect, instr_ready, instr_valid;
  logic [31:0] imem_a, imem_rd, redirect_pc, instr, instr_pc;
  int          total, bad;
  int unsigned q[$];
  logic [31:0] mpc;
  bit          halted;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
  logic misalign;
`else
  localparam bit MIS = 1'b0;
  logic misalign;
  assign misalign = 1'b0;
`endif
  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 ^ 32'h5A5A_1234;
  endfunction
  assign imem_rd = word(imem_a);
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    check("valid", {31'b0, instr_valid}, {31'b0, q.size() > 0});
    check("imem_a", imem_a, mpc);
    check("misalign", {31'b0, misalign}, {31'b0, halted});
    if (q.size() > 0) begin
      check("instr_pc", instr_pc, q[0]);
      check("instr", instr, word(q[0]));
    end
  endtask
  task automatic step(input logic r, input logic [31:0] rp, input logic rdy);
    check_outputs();
    redirect = r;
    redirect_pc = rp;
    instr_ready = rdy;
    if (!halted) begin
      if (r) begin
        q.delete();
        if (MIS && rp[1:0] != 2'b00) halted = 1'b1;
        else mpc = rp & 32'hFFFF_FFFC;
      end else begin
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (q.size() < 2) begin
          q.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_imem_a"}, imem_a, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    #1 reset_checks("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst_hold");
    reset = 1'b0;
    q.delete();
    mpc = 32'h0;
    halted = 1'b0;
  endtask
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    mpc = 32'h0;
    halted = 1'b0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 90; i++) step(1'b0, 32'h0, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 499) do_reset();
      step($urandom_range(7) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(2) != 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
